// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: widths, Y86 register
// encodings and the fixed requester slots feeding the writeback arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 32;
  localparam int NUM_WB_REQ = 4;
  localparam int WR_CNT_W   = 16;

  typedef enum logic [REG_ADDR_W-1:0] {
    EAX = 3'd0,
    ECX = 3'd1,
    EDX = 3'd2,
    EBX = 3'd3,
    ESP = 3'd4,
    EBP = 3'd5,
    ESI = 3'd6,
    EDI = 3'd7
  } y86_reg_e;

  localparam int WB_ALU   = 0;
  localparam int WB_MEM   = 1;
  localparam int WB_ESP   = 2;
  localparam int WB_SPARE = 3;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters, the arbiter and the register file:
// request handshake, the two write ports, busy mask and write counter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ    = regfile_pkg::NUM_WB_REQ,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int CNT_W      = regfile_pkg::WR_CNT_W
);
  import regfile_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0]     req_data;
  logic                          stall;
  logic                          write1;
  logic [REG_ADDR_W-1:0]         register1;
  logic [DATA_W-1:0]             value1;
  logic                          write2;
  logic [REG_ADDR_W-1:0]         register2;
  logic [DATA_W-1:0]             value2;
  logic [2**REG_ADDR_W-1:0]      busy_mask;
  logic [CNT_W-1:0]              wr_count;

  modport slave (
    input  req_valid, req_reg, req_data, stall,
    output req_ready, write1, register1, value1, write2, register2, value2,
           busy_mask, wr_count
  );

  modport master (
    output req_valid, req_reg, req_data, stall,
    input  req_ready, write1, register1, value1, write2, register2, value2,
           busy_mask, wr_count
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick2.sv
// Combinational round-robin picker: selects up to two valid requests starting at
// rrPtr, the second one only if it targets a different register than the first.
module rr_pick2 #(
  parameter  int NUM_REQ    = 4,
  parameter  int REG_ADDR_W = 3,
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]            valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] regs,
  input  logic [PTR_W-1:0]              rrPtr,
  output logic [NUM_REQ-1:0]            grantA,
  output logic [NUM_REQ-1:0]            grantB,
  output logic                          hasA,
  output logic                          hasB,
  output logic [PTR_W-1:0]              lastIdx
);
  import regfile_pkg::*;

  logic [REG_ADDR_W-1:0] regArr [NUM_REQ];
  logic [REG_ADDR_W-1:0] regA;
  logic [PTR_W-1:0]      scanIdx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign regArr[gi] = regs[gi*REG_ADDR_W +: REG_ADDR_W];
  end

  // lastIdx tracks the later of the two grants in scan order, which is what
  // the pointer must step past.
  always_comb begin
    grantA  = '0;
    grantB  = '0;
    hasA    = 1'b0;
    hasB    = 1'b0;
    lastIdx = '0;
    regA    = '0;
    scanIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = PTR_W'((int'(rrPtr) + k) % NUM_REQ);
      if (valid[scanIdx]) begin
        if (!hasA) begin
          hasA            = 1'b1;
          grantA[scanIdx] = 1'b1;
          regA            = regArr[scanIdx];
          lastIdx         = scanIdx;
        end else if (!hasB && (regArr[scanIdx] != regA)) begin
          hasB            = 1'b1;
          grantB[scanIdx] = 1'b1;
          lastIdx         = scanIdx;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: grants up to two requesters per cycle into the two
// register-file write ports, with a registered one-cycle issue stage.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = regfile_pkg::NUM_WB_REQ,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int CNT_W      = regfile_pkg::WR_CNT_W
) (
  input logic                  clock,
  input logic                  reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  import regfile_pkg::*;

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [PTR_W-1:0]      rrPtrReg;
  logic [PTR_W-1:0]      rrPtrNext;
  logic [NUM_REQ-1:0]    grantA;
  logic [NUM_REQ-1:0]    grantB;
  logic                  hasA;
  logic                  hasB;
  logic [PTR_W-1:0]      lastIdx;
  logic                  takeA;
  logic                  takeB;
  logic [REG_ADDR_W-1:0] selRegA;
  logic [REG_ADDR_W-1:0] selRegB;
  logic [DATA_W-1:0]     selDataA;
  logic [DATA_W-1:0]     selDataB;

  logic                  write1Reg;
  logic [REG_ADDR_W-1:0] register1Reg;
  logic [DATA_W-1:0]     value1Reg;
  logic                  write2Reg;
  logic [REG_ADDR_W-1:0] register2Reg;
  logic [DATA_W-1:0]     value2Reg;
  logic [CNT_W-1:0]      wrCountReg;

  rr_pick2 #(
    .NUM_REQ    (NUM_REQ),
    .REG_ADDR_W (REG_ADDR_W)
  ) picker (
    .valid   (bus.req_valid),
    .regs    (bus.req_reg),
    .rrPtr   (rrPtrReg),
    .grantA  (grantA),
    .grantB  (grantB),
    .hasA    (hasA),
    .hasB    (hasB),
    .lastIdx (lastIdx)
  );

  assign takeA = hasA && !bus.stall;
  assign takeB = hasB && !bus.stall;

  assign bus.req_ready = (reset_n && !bus.stall) ? (grantA | grantB) : '0;

  assign rrPtrNext = (lastIdx == PTR_W'(NUM_REQ - 1)) ? '0 : lastIdx + PTR_W'(1);

  // Grants are one-hot, so an AND-OR mux selects each slot's payload.
  always_comb begin
    selRegA  = '0;
    selRegB  = '0;
    selDataA = '0;
    selDataB = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      selRegA  = selRegA  | ({REG_ADDR_W{grantA[i]}} & bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W]);
      selRegB  = selRegB  | ({REG_ADDR_W{grantB[i]}} & bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W]);
      selDataA = selDataA | ({DATA_W{grantA[i]}}     & bus.req_data[i*DATA_W +: DATA_W]);
      selDataB = selDataB | ({DATA_W{grantB[i]}}     & bus.req_data[i*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rrPtrReg     <= '0;
      write1Reg    <= 1'b0;
      register1Reg <= '0;
      value1Reg    <= '0;
      write2Reg    <= 1'b0;
      register2Reg <= '0;
      value2Reg    <= '0;
      wrCountReg   <= '0;
    end else begin
      write1Reg  <= takeA;
      write2Reg  <= takeB;
      wrCountReg <= wrCountReg + CNT_W'(write1Reg) + CNT_W'(write2Reg);
      if (takeA) begin
        register1Reg <= selRegA;
        value1Reg    <= selDataA;
        rrPtrReg     <= rrPtrNext;
      end
      if (takeB) begin
        register2Reg <= selRegB;
        value2Reg    <= selDataB;
      end
    end
  end

  assign bus.write1    = write1Reg;
  assign bus.register1 = register1Reg;
  assign bus.value1    = value1Reg;
  assign bus.write2    = write2Reg;
  assign bus.register2 = register2Reg;
  assign bus.value2    = value2Reg;
  assign bus.wr_count  = wrCountReg;

  // A register is busy while any requester targets it or a port is writing it.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    logic hit;
    always_comb begin
      hit = (write1Reg && (register1Reg == REG_ADDR_W'(gi))) ||
            (write2Reg && (register2Reg == REG_ADDR_W'(gi)));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && (bus.req_reg[i*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(gi)))
          hit = 1'b1;
      end
    end
    assign bus.busy_mask[gi] = hit;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, single/dual grants, register
// conflicts, round-robin fairness, stall and counter wrap.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clock;
  logic reset_n;
  int   checks;
  int   fails;

  regfile_wb_arbiter_if #(.NUM_REQ(4), .REG_ADDR_W(3), .DATA_W(32), .CNT_W(16)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(4), .REG_ADDR_W(3), .DATA_W(32), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input int i, input logic [2:0] r, input logic [31:0] d);
    bus.req_reg[i*3 +: 3]   = r;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    reset_n       = 1'b0;
    bus.stall     = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_reg   = '0;
    bus.req_data  = '0;

    // Reset state after a clock edge with reset held low
    #7;
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_write1", bus.write1, 1'b0);
    chk("rst_write2", bus.write2, 1'b0);
    chk("rst_reg1", bus.register1, 3'd0);
    chk("rst_val1", bus.value1, 32'd0);
    chk("rst_reg2", bus.register2, 3'd0);
    chk("rst_val2", bus.value2, 32'd0);
    chk("rst_count", bus.wr_count, 16'd0);
    bus.req_valid = 4'b0000;
    #1;
    chk("rst_busy", bus.busy_mask, 8'h00);
    #5 reset_n = 1'b1;
    tick();

    // Reset asserted while a write is on the port
    setReq(0, EBX, 32'h1111_1111);
    bus.req_valid = 4'b0001;
    tick();
    chk("mid_write1_pre", bus.write1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_write1", bus.write1, 1'b0);
    chk("mid_reg1", bus.register1, 3'd0);
    chk("mid_val1", bus.value1, 32'd0);
    chk("mid_count", bus.wr_count, 16'd0);
    chk("mid_ready", bus.req_ready, 4'b0000);
    bus.req_valid = 4'b0000;
    #1;
    chk("mid_busy", bus.busy_mask, 8'h00);
    #1 reset_n = 1'b1;
    tick();

    // Single request
    setReq(0, EBX, 32'hDEAD_BEEF);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_busy", bus.busy_mask, 8'h08);
    tick();
    chk("single_write1", bus.write1, 1'b1);
    chk("single_reg1", bus.register1, 3'd3);
    chk("single_val1", bus.value1, 32'hDEAD_BEEF);
    chk("single_write2", bus.write2, 1'b0);
    chk("single_count", bus.wr_count, 16'd0);

    // Lone request from requester 3 wraps the pointer back to 0
    setReq(3, EDI, 32'hA5A5_A5A5);
    bus.req_valid = 4'b1000;
    #1;
    chk("r3_ready", bus.req_ready, 4'b1000);
    chk("r3_busy", bus.busy_mask, 8'h88);
    tick();
    chk("r3_reg1", bus.register1, 3'd7);
    chk("r3_val1", bus.value1, 32'hA5A5_A5A5);
    chk("r3_count", bus.wr_count, 16'd1);

    // Dual distinct registers
    setReq(0, EDX, 32'h2222_2222);
    setReq(1, EBP, 32'h5555_5555);
    bus.req_valid = 4'b0011;
    #1;
    chk("dual_ready", bus.req_ready, 4'b0011);
    chk("dual_busy", bus.busy_mask, 8'hA4);
    tick();
    chk("dual_write1", bus.write1, 1'b1);
    chk("dual_reg1", bus.register1, 3'd2);
    chk("dual_val1", bus.value1, 32'h2222_2222);
    chk("dual_write2", bus.write2, 1'b1);
    chk("dual_reg2", bus.register2, 3'd5);
    chk("dual_val2", bus.value2, 32'h5555_5555);
    chk("dual_count_pre", bus.wr_count, 16'd2);
    bus.req_valid = 4'b0000;
    tick();
    chk("dual_idle_w1", bus.write1, 1'b0);
    chk("dual_idle_w2", bus.write2, 1'b0);
    chk("dual_hold_reg2", bus.register2, 3'd5);
    chk("dual_hold_val2", bus.value2, 32'h5555_5555);
    chk("dual_count", bus.wr_count, 16'd4);

    // Pointer is 2 here; requester 3 alone brings it back to 0
    setReq(3, ECX, 32'h3333_3333);
    bus.req_valid = 4'b1000;
    #1;
    chk("realign_ready", bus.req_ready, 4'b1000);
    tick();
    chk("realign_reg1", bus.register1, 3'd1);

    // Same-register conflict: req0 then req2, never both on one cycle
    setReq(0, ESP, 32'h4040_4040);
    setReq(2, ESP, 32'h4242_4242);
    bus.req_valid = 4'b0101;
    #1;
    chk("conf_ready1", bus.req_ready, 4'b0001);
    chk("conf_busy", bus.busy_mask, 8'h12);
    tick();
    chk("conf_w1_c1", bus.write1, 1'b1);
    chk("conf_reg1_c1", bus.register1, 3'd4);
    chk("conf_val1_c1", bus.value1, 32'h4040_4040);
    chk("conf_w2_c1", bus.write2, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("conf_ready2", bus.req_ready, 4'b0100);
    tick();
    chk("conf_w1_c2", bus.write1, 1'b1);
    chk("conf_reg1_c2", bus.register1, 3'd4);
    chk("conf_val1_c2", bus.value1, 32'h4242_4242);
    chk("conf_w2_c2", bus.write2, 1'b0);

    // Pointer is 3; requester 3 alone wraps it to 0
    setReq(3, ESI, 32'h3636_3636);
    bus.req_valid = 4'b1000;
    #1;
    chk("wrap_ready", bus.req_ready, 4'b1000);
    tick();
    chk("wrap_reg1", bus.register1, 3'd6);
    chk("wrap_w2", bus.write2, 1'b0);

    // Fairness: all four valid with distinct registers
    for (int i = 0; i < 4; i++) setReq(i, 3'(i), 32'hA0 + 32'(i));
    bus.req_valid = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      #1;
      chk($sformatf("fair_ready_%0d", r), bus.req_ready, (r % 2 == 0) ? 4'b0011 : 4'b1100);
      tick();
      chk($sformatf("fair_w1_%0d", r), bus.write1, 1'b1);
      chk($sformatf("fair_w2_%0d", r), bus.write2, 1'b1);
      chk($sformatf("fair_reg1_%0d", r), bus.register1, (r % 2 == 0) ? 3'd0 : 3'd2);
      chk($sformatf("fair_reg2_%0d", r), bus.register2, (r % 2 == 0) ? 3'd1 : 3'd3);
      chk($sformatf("fair_val1_%0d", r), bus.value1, (r % 2 == 0) ? 32'hA0 : 32'hA2);
      chk($sformatf("fair_val2_%0d", r), bus.value2, (r % 2 == 0) ? 32'hA1 : 32'hA3);
    end

    // Stall with all requesters valid
    bus.stall = 1'b1;
    #1;
    chk("stall_ready", bus.req_ready, 4'b0000);
    chk("stall_busy", bus.busy_mask, 8'h0F);
    tick();
    chk("stall_w1", bus.write1, 1'b0);
    chk("stall_w2", bus.write2, 1'b0);
    chk("stall_hold_reg1", bus.register1, 3'd2);
    bus.stall = 1'b0;
    #1;
    chk("unstall_ready", bus.req_ready, 4'b0011);
    tick();
    chk("unstall_reg1", bus.register1, 3'd0);
    chk("unstall_reg2", bus.register2, 3'd1);
    bus.req_valid = 4'b0000;

    // Counter wrap: fresh reset, then 65535 writes, then 2 more
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("wrap_cnt_zero", bus.wr_count, 16'd0);
    setReq(0, EAX, 32'h0000_0001);
    setReq(1, ECX, 32'h0000_0002);
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 32767; i++) tick();
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("cnt_ffff", bus.wr_count, 16'hFFFF);
    bus.req_valid = 4'b0011;
    tick();
    bus.req_valid = 4'b0000;
    chk("cnt_ffff_hold", bus.wr_count, 16'hFFFF);
    tick();
    chk("cnt_wrapped", bus.wr_count, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
